alu_ctrl_seq: RTL

//  Registered, parametrised ALU control unit with RV32M support and a multi-cycle sequencer.
//  - Decodes ALUOp/funct3/funct7/opcode bits into an ALU control code, covering base, shift, LUI/AUIPC and M-extension ops.
//  - For MUL*/DIV*/REM* it starts the external MDU and holds the pipeline until the fixed op latency elapses.
//  - Sits between the main decoder and the ALU/MDU datapath.

---
 rtl/alu_ctrl_seq_pkg.sv | 51 +++++
 rtl/alu_ctrl_seq_decode.sv | 66 ++++++
 rtl/alu_ctrl_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/alu_ctrl_seq_pkg.sv
// Shared ALU control encodings: control codes, ALUOp values, sequencer states, decode result.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_ctrl_seq_pkg;

    localparam int CODE_W = 5;
    typedef logic [CODE_W-1:0] code_t;

    // ALU / MDU control codes
    localparam code_t ALU_ADD     = 5'd0;
    localparam code_t ALU_SUB     = 5'd1;
    localparam code_t ALU_AND     = 5'd2;
    localparam code_t ALU_OR      = 5'd3;
    localparam code_t ALU_XOR     = 5'd4;
    localparam code_t ALU_SLT     = 5'd5;
    localparam code_t ALU_SLTU    = 5'd6;
    localparam code_t ALU_SLL     = 5'd7;
    localparam code_t ALU_AUIPC   = 5'd8;
    localparam code_t ALU_LUI     = 5'd9;
    localparam code_t ALU_SRL     = 5'd10;
    localparam code_t ALU_SRA     = 5'd11;
    localparam code_t ALU_MUL     = 5'd16;
    localparam code_t ALU_MULH    = 5'd17;
    localparam code_t ALU_MULHSU  = 5'd18;
    localparam code_t ALU_MULHU   = 5'd19;
    localparam code_t ALU_DIV     = 5'd20;
    localparam code_t ALU_DIVU    = 5'd21;
    localparam code_t ALU_REM     = 5'd22;
    localparam code_t ALU_REMU    = 5'd23;
    localparam code_t ALU_ILLEGAL = 5'd31;

    // ALUOp encodings from the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_UTYPE = 2'b11;

    // Sequencer states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Decoder result: code plus multi-cycle classification
    typedef struct packed {
        code_t code;
        logic  is_multi;
        logic  is_div;
    } dec_t;

endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// Combinational decode of ALUOp/funct fields into an ALU control code and MDU class.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; consumer samples the result when it accepts the instruction.
module alu_ctrl_decode
    import alu_ctrl_seq_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       funct7b0_i,
    input  logic       opb5_i,
    output dec_t       dec_o
);

    // Field decode; anything not matched falls through to ILLEGAL
    always_comb begin
        dec_o.code     = ALU_ILLEGAL;
        dec_o.is_multi = 1'b0;
        dec_o.is_div   = 1'b0;
        case (alu_op_i)
            ALUOP_ADD: dec_o.code = ALU_ADD;
            ALUOP_SUB: dec_o.code = ALU_SUB;
            ALUOP_FUNCT: begin
                if (opb5_i && funct7b0_i) begin
                    // R-type with funct7[0] set is the M extension; illegal when not built in
                    if (EN_M) begin
                        dec_o.is_multi = 1'b1;
                        dec_o.is_div   = funct3_i[2];
                        case (funct3_i)
                            3'b000:  dec_o.code = ALU_MUL;
                            3'b001:  dec_o.code = ALU_MULH;
                            3'b010:  dec_o.code = ALU_MULHSU;
                            3'b011:  dec_o.code = ALU_MULHU;
                            3'b100:  dec_o.code = ALU_DIV;
                            3'b101:  dec_o.code = ALU_DIVU;
                            3'b110:  dec_o.code = ALU_REM;
                            default: dec_o.code = ALU_REMU;
                        endcase
                    end
                end else begin
                    case (funct3_i)
                        // instr[30] only means SUB for register-register adds
                        3'b000:  dec_o.code = (opb5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                        3'b001:  dec_o.code = ALU_SLL;
                        3'b010:  dec_o.code = ALU_SLT;
                        3'b011:  dec_o.code = ALU_SLTU;
                        3'b100:  dec_o.code = ALU_XOR;
                        3'b101:  dec_o.code = funct7b5_i ? ALU_SRA : ALU_SRL;
                        3'b110:  dec_o.code = ALU_OR;
                        default: dec_o.code = ALU_AND;
                    endcase
                end
            end
            default: begin
                if (funct3_i == 3'b000) begin
                    dec_o.code = ALU_AUIPC;
                end else if (funct3_i == 3'b001) begin
                    dec_o.code = ALU_LUI;
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control unit with MUL/DIV sequencer: decodes fields, starts MDU, holds pipe.
// Latency: 1 cycle for single-cycle ops; MUL_LAT / DIV_LAT cycles accept-to-done for MDU ops.
// Backpressure: combinational stall holds upstream while an MDU op is in flight; flush aborts it.
module alu_ctrl_seq
    import alu_ctrl_seq_pkg::*;
#(
    parameter int CTRL_W  = 5,
    parameter bit EN_M    = 1'b1,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              flush,
    input  logic [1:0]        alu_op,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              funct7b0,
    input  logic              opb5,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              ctrl_valid,
    output logic              mdu_start,
    output logic              stall,
    output logic              done,
    output logic              illegal
);

    dec_t              dec;
    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CTRL_W-1:0] alu_ctrl_q;
    logic [CTRL_W-1:0] alu_ctrl_d;
    logic              ctrl_valid_q;
    logic              mdu_start_q;
    logic              illegal_q;
    logic              accept;
    logic              busy;

    alu_ctrl_decode #(
        .EN_M (EN_M)
    ) u_decode (
        .alu_op_i   (alu_op),
        .funct3_i   (funct3),
        .funct7b5_i (funct7b5),
        .funct7b0_i (funct7b0),
        .opb5_i     (opb5),
        .dec_o      (dec)
    );

    assign busy       = (state_q == ST_BUSY);
    // A flush in IDLE kills the instruction presented in the same cycle
    assign accept     = (state_q == ST_IDLE) && in_valid && !flush;
    assign alu_ctrl_d = CTRL_W'(dec.code);
    // Counter load: remaining BUSY cycles after the start cycle
    assign cnt_d      = dec.is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

    // Sequencer FSM with registered control outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            alu_ctrl_q   <= '0;
            ctrl_valid_q <= 1'b0;
            mdu_start_q  <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            mdu_start_q <= 1'b0;
            illegal_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ctrl_valid_q <= 1'b0;
                    if (accept) begin
                        alu_ctrl_q   <= alu_ctrl_d;
                        ctrl_valid_q <= 1'b1;
                        illegal_q    <= (dec.code == ALU_ILLEGAL);
                        if (dec.is_multi) begin
                            state_q     <= ST_BUSY;
                            cnt_q       <= cnt_d;
                            mdu_start_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    // in_valid is ignored here, including the done cycle
                    if (flush || cnt_q == '0) begin
                        state_q      <= ST_IDLE;
                        cnt_q        <= '0;
                        ctrl_valid_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    // Done/stall/valid are qualified by flush in the same cycle so an aborted op never completes
    always_comb begin
        stall = (accept && dec.is_multi) || (busy && (cnt_q != '0) && !flush);
        done  = busy && (cnt_q == '0) && !flush;
    end

    assign alu_ctrl   = alu_ctrl_q;
    assign ctrl_valid = ctrl_valid_q && !(busy && flush);
    assign mdu_start  = mdu_start_q;
    assign illegal    = illegal_q;

endmodule
